// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the MEM-stage access controller.
package mem_stage_ctrl_pkg;

    localparam int unsigned DATA_W        = 16;
    localparam int unsigned CNT_W         = 8;
    localparam int unsigned TIMEOUT_LIMIT = 255;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_HALT  = 3'd4
    } state_e;

    // Request captured at issue and held until IDLE is re-entered.
    typedef struct packed {
        logic              wr;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_wait_cnt.sv
// Wait-cycle counter for an outstanding memory access; flags the timeout limit.
module mem_wait_cnt
    import mem_stage_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count   = count_q;
    assign expired = (count_q == CNT_W'(TIMEOUT_LIMIT));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues one load/store at a time, stalls the pipe until it completes.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic              op_rd,
    input  logic              op_wr,
    input  logic              op_dump,
    input  logic [DATA_W-1:0] op_addr,
    input  logic [DATA_W-1:0] op_wdata,
    input  logic              flush,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    input  logic              mem_busy,
    output logic              pipe_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              halted,
    output logic              err
);

    state_e            state_q, state_d;
    mem_req_t          req_q, req_d;
    logic              mem_en_q, mem_en_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              halted_q, halted_d;
    logic              err_q, err_d;
    logic              flushed_q, flushed_d;

    logic              mem_op_c;
    logic              dump_c;
    logic              pipe_en_c;
    logic              cnt_clr;
    logic              cnt_inc;
    logic [CNT_W-1:0]  cnt_count;
    logic              cnt_expired;

    assign mem_op_c = op_valid & ~flush & (op_rd | op_wr);
    assign dump_c   = op_valid & op_dump & ~flush & ~mem_op_c;

    // Count only while waiting below the limit; the limit itself is the timeout.
    assign cnt_clr = (state_q == S_ISSUE);
    assign cnt_inc = (state_q == S_WAIT) & ~mem_done
                   & (cnt_count != CNT_W'(TIMEOUT_LIMIT));

    mem_wait_cnt u_wait_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .count   (cnt_count),
        .expired (cnt_expired)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        mem_en_d   = 1'b0;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        halted_d   = halted_q;
        err_d      = err_q;
        flushed_d  = flushed_q;

        unique case (state_q)
            S_IDLE: begin
                flushed_d = 1'b0;
                if (mem_op_c && !mem_busy) begin
                    state_d     = S_ISSUE;
                    mem_en_d    = 1'b1;
                    req_d.wr    = op_wr;
                    req_d.addr  = op_addr;
                    req_d.wdata = op_wdata;
                    if (op_rd && op_wr) begin
                        err_d = 1'b1;
                    end
                end else if (dump_c) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                if (flush) begin
                    flushed_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    flushed_d = 1'b1;
                end
                // A late completion on the limit cycle still counts as normal.
                if (mem_done) begin
                    state_d = S_RESP;
                    if (!req_q.wr) begin
                        rd_data_d  = mem_rdata;
                        rd_valid_d = ~flushed_q & ~flush;
                    end
                end else if (cnt_expired) begin
                    state_d   = S_RESP;
                    err_d     = 1'b1;
                    rd_data_d = '0;
                end
            end
            S_RESP:  state_d = S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Stall decision must act on the op currently held, so it is not registered.
    always_comb begin
        pipe_en_c = 1'b0;
        unique case (state_q)
            S_IDLE:  pipe_en_c = ~mem_op_c & ~dump_c;
            S_RESP:  pipe_en_c = 1'b1;
            default: pipe_en_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            req_q      <= '0;
            mem_en_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
            flushed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            mem_en_q   <= mem_en_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            halted_q   <= halted_d;
            err_q      <= err_d;
            flushed_q  <= flushed_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_wr    = req_q.wr;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign halted    = halted_q;
    assign err       = err_q;
    assign pipe_en   = rst & pipe_en_c;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with hand-computed expectations.
module tb_mem_stage_ctrl;

    logic        clk;
    logic        rst;
    logic        op_valid, op_rd, op_wr, op_dump, flush;
    logic [15:0] op_addr, op_wdata;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_done, mem_busy;
    logic        pipe_en;
    logic [15:0] rd_data;
    logic        rd_valid, halted, err;

    int n_total = 0;
    int n_pass  = 0;

    mem_stage_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_rd     (op_rd),
        .op_wr     (op_wr),
        .op_dump   (op_dump),
        .op_addr   (op_addr),
        .op_wdata  (op_wdata),
        .flush     (flush),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .mem_busy  (mem_busy),
        .pipe_en   (pipe_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .halted    (halted),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_op();
        op_valid = 1'b0; op_rd = 1'b0; op_wr = 1'b0; op_dump = 1'b0; flush = 1'b0;
    endtask

    initial begin
        int n_wait;
        int n_en;
        int stalls;

        rst = 1'b0;
        clear_op();
        op_addr = '0; op_wdata = '0;
        mem_rdata = '0; mem_done = 1'b0; mem_busy = 1'b0;

        // Reset values
        cyc(); cyc(); #1;
        chk("rst_mem_en", 16'(mem_en), 16'h0);
        chk("rst_mem_wr", 16'(mem_wr), 16'h0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_wdata", mem_wdata, 16'h0000);
        chk("rst_rd_data", rd_data, 16'h0000);
        chk("rst_rd_valid", 16'(rd_valid), 16'h0);
        chk("rst_halted", 16'(halted), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        chk("rst_pipe_en", 16'(pipe_en), 16'h0);
        rst = 1'b1; #1;
        chk("idle_pipe_en", 16'(pipe_en), 16'h1);
        cyc(); #1;
        chk("post_rst_no_req", 16'(mem_en), 16'h0);

        // Load: done 3 cycles after mem_en
        stalls = 0;
        op_valid = 1'b1; op_rd = 1'b1; op_addr = 16'h0040; #1;
        if (!pipe_en) stalls++;
        cyc(); #1;
        if (!pipe_en) stalls++;
        chk("ld_issue_en", 16'(mem_en), 16'h1);
        chk("ld_issue_addr", mem_addr, 16'h0040);
        chk("ld_issue_wr", 16'(mem_wr), 16'h0);
        cyc(); #1;
        if (!pipe_en) stalls++;
        chk("ld_wait_en", 16'(mem_en), 16'h0);
        cyc(); #1;
        if (!pipe_en) stalls++;
        cyc();
        mem_done = 1'b1; mem_rdata = 16'hBEEF; #1;
        if (!pipe_en) stalls++;
        chk("ld_wait_addr_stable", mem_addr, 16'h0040);
        cyc();
        mem_done = 1'b0; #1;
        chk("ld_stall_cycles", 16'(stalls), 16'd5);
        chk("ld_rd_valid", 16'(rd_valid), 16'h1);
        chk("ld_rd_data", rd_data, 16'hBEEF);
        chk("ld_resp_pipe_en", 16'(pipe_en), 16'h1);
        cyc();
        clear_op(); #1;
        chk("ld_rd_valid_pulse", 16'(rd_valid), 16'h0);
        chk("ld_idle_pipe_en", 16'(pipe_en), 16'h1);

        // Stray mem_done in IDLE is ignored
        mem_done = 1'b1; mem_rdata = 16'h5555;
        cyc();
        mem_done = 1'b0; #1;
        chk("idle_done_rd_valid", 16'(rd_valid), 16'h0);
        chk("idle_done_rd_data", rd_data, 16'hBEEF);
        chk("idle_done_no_en", 16'(mem_en), 16'h0);

        // Store: done 1 cycle after mem_en
        op_valid = 1'b1; op_wr = 1'b1; op_addr = 16'h0002; op_wdata = 16'h1234;
        cyc(); #1;
        chk("st_issue_en", 16'(mem_en), 16'h1);
        chk("st_issue_wr", 16'(mem_wr), 16'h1);
        chk("st_issue_addr", mem_addr, 16'h0002);
        cyc();
        mem_done = 1'b1; #1;
        chk("st_wait_wr", 16'(mem_wr), 16'h1);
        chk("st_wait_wdata", mem_wdata, 16'h1234);
        chk("st_wait_pipe_en", 16'(pipe_en), 16'h0);
        cyc();
        mem_done = 1'b0; #1;
        chk("st_resp_rd_valid", 16'(rd_valid), 16'h0);
        chk("st_resp_pipe_en", 16'(pipe_en), 16'h1);
        chk("st_rd_data_kept", rd_data, 16'hBEEF);
        cyc();
        clear_op(); #1;

        // Busy memory for 4 cycles, then issue; flush mid-WAIT suppresses rd_valid
        op_valid = 1'b1; op_rd = 1'b1; op_addr = 16'h0100; mem_busy = 1'b1;
        n_en = 0;
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (mem_en) n_en++;
            if (!pipe_en) stalls++;
            cyc();
        end
        chk("busy_no_en", 16'(n_en), 16'd0);
        chk("busy_stall", 16'(stalls), 16'd4);
        mem_busy = 1'b0;
        cyc(); #1;
        chk("busy_then_issue", 16'(mem_en), 16'h1);
        chk("busy_issue_addr", mem_addr, 16'h0100);
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        cyc();
        mem_done = 1'b1; mem_rdata = 16'hCAFE;
        cyc();
        mem_done = 1'b0; #1;
        chk("flush_wait_rd_valid", 16'(rd_valid), 16'h0);
        chk("flush_wait_rd_data", rd_data, 16'hCAFE);
        chk("flush_wait_pipe_en", 16'(pipe_en), 16'h1);
        cyc();
        clear_op();

        // Flush in IDLE suppresses the issue
        op_valid = 1'b1; op_rd = 1'b1; flush = 1'b1; #1;
        chk("flush_idle_pipe_en", 16'(pipe_en), 16'h1);
        cyc(); #1;
        chk("flush_idle_no_en", 16'(mem_en), 16'h0);
        clear_op();

        // Timeout: load with no completion
        op_valid = 1'b1; op_rd = 1'b1; op_addr = 16'h0200;
        cyc(); #1;
        chk("to_issue_en", 16'(mem_en), 16'h1);
        chk("to_err_before", 16'(err), 16'h0);
        n_wait = 0;
        n_en = 0;
        do begin
            cyc(); #1;
            if (mem_en) n_en++;
            if (!pipe_en) n_wait++;
        end while (!pipe_en && n_wait < 400);
        chk("to_wait_len_ok", 16'(n_wait >= 255 && n_wait <= 256), 16'h1);
        chk("to_no_en_in_wait", 16'(n_en), 16'd0);
        chk("to_err", 16'(err), 16'h1);
        chk("to_rd_data", rd_data, 16'h0000);
        chk("to_rd_valid", 16'(rd_valid), 16'h0);
        chk("to_resp_pipe_en", 16'(pipe_en), 16'h1);
        cyc();
        clear_op();

        // Reset asserted mid-WAIT
        op_valid = 1'b1; op_rd = 1'b1; op_addr = 16'h0300;
        cyc(); cyc(); cyc();
        rst = 1'b0; clear_op(); #1;
        chk("rstw_mem_addr", mem_addr, 16'h0000);
        chk("rstw_err", 16'(err), 16'h0);
        chk("rstw_pipe_en", 16'(pipe_en), 16'h0);
        chk("rstw_rd_data", rd_data, 16'h0000);
        cyc();
        rst = 1'b1;
        mem_done = 1'b1; mem_rdata = 16'h7777;
        cyc();
        mem_done = 1'b0; #1;
        chk("rstw_late_done_rd_valid", 16'(rd_valid), 16'h0);
        chk("rstw_late_done_no_en", 16'(mem_en), 16'h0);
        chk("rstw_idle_pipe_en", 16'(pipe_en), 16'h1);

        // Read+write conflict: error, write wins; error is sticky
        op_valid = 1'b1; op_rd = 1'b1; op_wr = 1'b1; op_addr = 16'h0008; op_wdata = 16'hA5A5;
        cyc(); #1;
        chk("rw_err", 16'(err), 16'h1);
        chk("rw_mem_wr", 16'(mem_wr), 16'h1);
        chk("rw_wdata", mem_wdata, 16'hA5A5);
        cyc();
        mem_done = 1'b1;
        cyc();
        mem_done = 1'b0; #1;
        chk("rw_rd_valid", 16'(rd_valid), 16'h0);
        cyc();
        clear_op();
        cyc(); cyc(); #1;
        chk("err_sticky", 16'(err), 16'h1);
        chk("err_no_stall", 16'(pipe_en), 16'h1);

        // Dump halts until reset
        op_valid = 1'b1; op_dump = 1'b1;
        cyc();
        clear_op(); #1;
        chk("halt_halted", 16'(halted), 16'h1);
        chk("halt_pipe_en", 16'(pipe_en), 16'h0);
        op_valid = 1'b1; op_rd = 1'b1; op_addr = 16'h0400;
        n_en = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            if (mem_en) n_en++;
        end
        chk("halt_no_en", 16'(n_en), 16'd0);
        chk("halt_held", 16'(halted), 16'h1);
        rst = 1'b0; clear_op(); #1;
        chk("halt_rst_halted", 16'(halted), 16'h0);
        chk("halt_rst_err", 16'(err), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset. The ports are `clk` (in, 1, rising-edge clock) and `rst` (in, 1, asynchronous active-low reset).
REQ-002 SHALL have port `op_valid` (in, 1): the EX/MEM stage holds a valid instruction.
REQ-003 SHALL have ports `op_rd` (in, 1, load; EX/MEM mem_to_reg), `op_wr` (in, 1, store; EX/MEM mem_write) and `op_dump` (in, 1, halt/dump instruction).
REQ-004 SHALL have ports `op_addr` (in, 16, ALU result address) and `op_wdata` (in, 16, store data, B operand).
REQ-005 SHALL have port `flush` (in, 1): squash the current EX/MEM op.
REQ-006 SHALL have ports `mem_en` (out, 1, request strobe), `mem_wr` (out, 1, 1=write), `mem_addr` (out, 16) and `mem_wdata` (out, 16).
REQ-007 SHALL have ports `mem_rdata` (in, 16), `mem_done` (in, 1, access complete) and `mem_busy` (in, 1, memory cannot accept a request).
REQ-008 SHALL have port `pipe_en` (out, 1): enable for the EX/MEM and upstream pipeline registers; 0 = stall.
REQ-009 SHALL have ports `rd_data` (out, 16, load result), `rd_valid` (out, 1, one-cycle pulse), `halted` (out, 1) and `err` (out, 1, sticky fault).

Function
REQ-010 SHALL implement a Moore FSM with states IDLE, ISSUE, WAIT, RESP and HALT.
REQ-011 SHALL define "memory op" as op_valid & ~flush & (op_rd | op_wr).
REQ-012 SHALL behave as follows in IDLE:
- memory op & ~mem_busy -> ISSUE, latching op_addr, op_wdata and op_wr into mem_addr, mem_wdata and mem_wr;
- memory op & mem_busy -> stay in IDLE with pipe_en=0;
- op_valid & op_dump & ~flush & no memory op -> HALT;
- otherwise -> stay in IDLE with pipe_en=1.
REQ-013 SHALL, when op_rd and op_wr are both set, set err and perform a write (write has priority).
REQ-014 SHALL assert mem_en for exactly the ISSUE cycle, then go to WAIT; mem_addr, mem_wdata and mem_wr stay stable from ISSUE until IDLE is re-entered.
REQ-015 SHALL behave as follows in WAIT:
- mem_done -> RESP; for a read, rd_data <= mem_rdata at that edge;
- mem_done is ignored in every state except WAIT.
REQ-016 SHALL hold pipe_en=0 in ISSUE, WAIT and HALT, and pipe_en=1 in RESP; RESP always returns to IDLE after one cycle, so the same op is never reissued.
REQ-017 SHALL assert rd_valid only in RESP, only for a read that was not flushed.
REQ-018 SHALL behave as follows when flush asserts:
- in IDLE: suppresses the issue;
- in ISSUE or WAIT: the access still completes (it is not cancellable), but rd_valid is suppressed.
REQ-019 SHALL implement an 8-bit wait counter:
- cleared on entry to WAIT and incremented each WAIT cycle without mem_done;
- on reaching 255 -> set err, rd_data <= 0x0000, go to RESP with rd_valid=0;
- mem_done arriving in the same cycle as count 255 wins (normal completion).
REQ-020 SHALL make err sticky until reset; err does not stall the pipeline.
REQ-021 SHALL hold halted=1 and pipe_en=0 in HALT, with no exit except reset.
REQ-022 SHALL never drive mem_en while in WAIT, RESP or HALT; at most one access is outstanding.

Reset
REQ-023 SHALL, while rst=0, force state=IDLE and drive mem_en=0, mem_wr=0, mem_addr=0x0000, mem_wdata=0x0000, rd_data=0x0000, rd_valid=0, halted=0, err=0, pipe_en=0, with the wait counter=0.
REQ-024 SHALL make reset asserted mid-access (ISSUE or WAIT) abandon the access immediately; a later mem_done is ignored.
REQ-025 SHALL issue no memory request in the first cycle after reset deassertion unless a memory op is present.

Structure
REQ-026 SHALL place the FSM state encoding, the data width (16) and the timeout limit (255) in the shared package.
REQ-027 SHALL implement the wait counter as sub-module `mem_wait_cnt` (ports clr, inc; outputs count and expired); all other logic stays in mem_stage_ctrl.

Verification
REQ-028 SHALL cover a load:
- stimulus: op_rd=1, op_addr=0x0040, mem_done 3 cycles after mem_en, mem_rdata=0xBEEF;
- response: one mem_en pulse, pipe_en=0 for 5 cycles, then rd_valid=1 with rd_data=0xBEEF for one cycle.
REQ-029 SHALL cover a store:
- stimulus: op_wr=1, op_addr=0x0002, op_wdata=0x1234, mem_done 1 cycle after mem_en;
- response: mem_wr=1 and mem_wdata=0x1234 held through WAIT; rd_valid stays 0.
REQ-030 SHALL cover a busy memory:
- stimulus: op_rd with mem_busy=1 for 4 cycles;
- response: no mem_en and pipe_en=0 for those 4 cycles, then ISSUE.
REQ-031 SHALL cover timeout:
- stimulus: load, mem_done never asserts;
- response: err=1 after 255 WAIT cycles, rd_data=0x0000, rd_valid=0, pipe_en=1 in RESP.
REQ-032 SHALL cover flush during WAIT and dump:
- flush during WAIT, then mem_done -> rd_valid=0;
- op_dump -> halted=1 and pipe_en=0 until rst=0.
REQ-033 SHALL cover reset mid-WAIT:
- stimulus: rst=0 asserted while in WAIT;
- response: all outputs at reset values immediately, and a subsequent mem_done produces no rd_valid.
